// File: rtl/mux_pkg.sv
// Shared constants for the scanning multiplexer: FSM state encodings and mode values.
package mux_pkg;
  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t MANUAL = 2'd1;
  localparam state_t SCAN   = 2'd2;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/dwell_counter.sv
// Counts the cycles a channel has been held in scan mode; last flags the final dwell cycle.
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);
  // Keep at least one bit so DWELL=1 still elaborates; last is then permanently high.
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LASTV = CW'(DWELL - 1);

  logic [CW-1:0] count;

  assign last = (count == LASTV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + CW'(1);
    end
  end
endmodule

// File: rtl/param_scan_mux.sv
// Registered N-channel multiplexer: manual selection via sel, or autonomous scan with
// a programmable dwell per channel and a wrap pulse on every return to channel 0.
module param_scan_mux
  import mux_pkg::*;
#(
  parameter  int NCH   = 8,
  parameter  int W     = 1,
  parameter  int DWELL = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH*W-1:0] a,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            en,
  output logic [W-1:0]    y,
  output logic [SELW-1:0] ch,
  output logic            valid,
  output logic            wrap
);
  localparam logic [SELW-1:0] LASTCH = SELW'(NCH - 1);
  localparam logic [SELW:0]   NCH_V  = (SELW + 1)'(NCH);

  state_t          state, state_nx;
  logic [SELW-1:0] ch_nx, idx, ch_next;
  logic [W-1:0]    ch_data;
  logic            valid_nx, wrap_nx, hold, clr, inc, dwell_last, sel_ok;

  assign sel_ok  = ({1'b0, sel} < NCH_V);
  assign ch_next = (ch == LASTCH) ? '0 : ch + SELW'(1);

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (inc),
    .last (dwell_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    if (en) state_nx = (mode == MODE_SCAN) ? SCAN : MANUAL;
  end

  // Decisions are keyed on the state being entered, so en/mode take effect on this edge.
  always_comb begin
    ch_nx    = ch;
    idx      = ch;
    valid_nx = 1'b0;
    wrap_nx  = 1'b0;
    hold     = 1'b1;
    clr      = 1'b1;
    inc      = 1'b0;
    case (state_nx)
      MANUAL: begin
        hold     = 1'b0;
        ch_nx    = sel;
        idx      = sel;
        valid_nx = sel_ok;
      end
      SCAN: begin
        hold     = 1'b0;
        valid_nx = 1'b1;
        if (state != SCAN) begin
          ch_nx = '0;
          idx   = '0;
        end else begin
          clr = 1'b0;
          inc = 1'b1;
          if (dwell_last) begin
            ch_nx   = ch_next;
            idx     = ch_next;
            wrap_nx = (ch == LASTCH);
          end
        end
      end
      default: ;
    endcase
  end

  // Out-of-range indices match no channel and yield zero.
  always_comb begin
    ch_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx == SELW'(k)) ch_data = a[k*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      if (!hold) begin
        y  <= ch_data;
        ch <= ch_nx;
      end
      valid <= valid_nx;
      wrap  <= wrap_nx;
    end
  end
endmodule

// File: tb/tb_param_scan_mux.sv
// Scoreboard bench for param_scan_mux: an 8x4-bit/DWELL=4 instance and a 6x1-bit/DWELL=1 instance.
module tb_param_scan_mux;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] a8;
  logic [2:0]  sel8, ch8;
  logic        mode8, en8, valid8, wrap8;
  logic [3:0]  y8;

  logic [5:0]  a6;
  logic [2:0]  sel6, ch6;
  logic        mode6, en6, valid6, wrap6;
  logic [0:0]  y6;

  param_scan_mux #(.NCH(8), .W(4), .DWELL(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .sel(sel8), .mode(mode8), .en(en8),
    .y(y8), .ch(ch8), .valid(valid8), .wrap(wrap8)
  );

  param_scan_mux #(.NCH(6), .W(1), .DWELL(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .a(a6), .sel(sel6), .mode(mode6), .en(en6),
    .y(y6), .ch(ch6), .valid(valid6), .wrap(wrap6)
  );

  typedef struct {
    string      nm;
    logic [3:0] y;
    logic [2:0] ch;
    logic       v;
    logic       w;
  } exp_t;

  exp_t q8[$];
  exp_t q6[$];
  exp_t e8, e6;
  int   errors = 0;
  int   checks = 0;

  task automatic cmp(input string nm, input logic [3:0] gy, input logic [3:0] ey,
                     input logic [2:0] gch, input logic [2:0] ech,
                     input logic gv, input logic ev, input logic gw, input logic ew);
    checks++;
    if ({gy, gch, gv, gw} !== {ey, ech, ev, ew}) begin
      errors++;
      $display("FAIL %s: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
               nm, gy, gch, gv, gw, ey, ech, ev, ew);
    end
  endtask

  // Expected response for the coming rising edge, then advance to the next falling edge.
  task automatic step8(input string nm, input logic [3:0] y, input logic [2:0] ch,
                       input logic v, input logic w);
    q8.push_back('{nm, y, ch, v, w});
    @(negedge clk);
  endtask

  task automatic step6(input string nm, input logic [3:0] y, input logic [2:0] ch,
                       input logic v, input logic w);
    q6.push_back('{nm, y, ch, v, w});
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q8.size() > 0) begin
      e8 = q8.pop_front();
      cmp(e8.nm, y8, e8.y, ch8, e8.ch, valid8, e8.v, wrap8, e8.w);
    end
  end

  always @(posedge clk) begin
    #1;
    if (q6.size() > 0) begin
      e6 = q6.pop_front();
      cmp(e6.nm, {3'b000, y6}, e6.y, ch6, e6.ch, valid6, e6.v, wrap6, e6.w);
    end
  end

  initial begin
    logic [3:0] ey;
    rst_n = 1'b0;
    a8 = 32'h7654_3210; sel8 = 3'd0; mode8 = 1'b0; en8 = 1'b0;
    a6 = 6'b101100;     sel6 = 3'd0; mode6 = 1'b0; en6 = 1'b0;
    repeat (2) @(negedge clk);
    cmp("reset_state", y8, 4'h0, ch8, 3'd0, valid8, 1'b0, wrap8, 1'b0);
    rst_n = 1'b1;
    step8("idle", 4'h0, 3'd0, 1'b0, 1'b0);

    en8 = 1'b1; sel8 = 3'd5;
    step8("man_sel5", 4'h5, 3'd5, 1'b1, 1'b0);
    sel8 = 3'd2;
    step8("man_sel2", 4'h2, 3'd2, 1'b1, 1'b0);

    mode8 = 1'b1;
    for (int i = 0; i <= 44; i++)
      step8($sformatf("scan_%0d", i), 4'((i / 4) % 8), 3'((i / 4) % 8), 1'b1, i == 32);

    mode8 = 1'b0; sel8 = 3'd6;
    step8("to_manual", 4'h6, 3'd6, 1'b1, 1'b0);

    mode8 = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i == 2) a8 = 32'h7654_321A;
      ey = ((i / 4) == 0 && i >= 2) ? 4'hA : 4'(i / 4);
      step8($sformatf("rescan_%0d", i), ey, 3'(i / 4), 1'b1, 1'b0);
    end

    en8 = 1'b0; a8 = 32'hFFFF_FFFF;
    step8("en_off", 4'h2, 3'd2, 1'b0, 1'b0);
    a8 = 32'h0;
    step8("en_frozen", 4'h2, 3'd2, 1'b0, 1'b0);
    a8 = 32'h7654_3210; en8 = 1'b1;
    step8("en_restart", 4'h0, 3'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++)
      step8($sformatf("scan_r%0d", i), 4'(i / 4), 3'(i / 4), 1'b1, 1'b0);

    #2 rst_n = 1'b0;
    #1 cmp("async_rst", y8, 4'h0, ch8, 3'd0, valid8, 1'b0, wrap8, 1'b0);
    step8("rst_held", 4'h0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step8("post_rst_entry", 4'h0, 3'd0, 1'b1, 1'b0);
    step8("post_rst_scan", 4'h0, 3'd0, 1'b1, 1'b0);

    en6 = 1'b1; mode6 = 1'b0; sel6 = 3'd7;
    step6("oor_sel7", 4'h0, 3'd7, 1'b0, 1'b0);
    sel6 = 3'd3;
    step6("n6_sel3", 4'h1, 3'd3, 1'b1, 1'b0);
    sel6 = 3'd6;
    step6("oor_sel6", 4'h0, 3'd6, 1'b0, 1'b0);
    sel6 = 3'd0;
    step6("n6_sel0", 4'h0, 3'd0, 1'b1, 1'b0);
    mode6 = 1'b1;
    for (int i = 0; i <= 7; i++)
      step6($sformatf("n6_scan_%0d", i), {3'b000, a6[i % 6]}, 3'(i % 6), 1'b1, i == 6);

    repeat (2) @(negedge clk);
    checks++;
    if (q8.size() != 0 || q6.size() != 0) begin
      errors++;
      $display("FAIL drain: pending q8=%0d q6=%0d, want 0", q8.size(), q6.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
